// File: rtl/rollover_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rollover_mon_pkg
// Brief    : Shared types for the rollover monitor (cause codes, event record).
//            Record gains a timestamp field when ROLLOVER_MON_TS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package rollover_mon_pkg;

    localparam int TS_W   = 16;
    localparam int IW_DEF = 8;

    typedef enum logic [1:0] {
        CAUSE_UP        = 2'd0,
        CAUSE_LOAD      = 2'd1,
        CAUSE_DOWN_WRAP = 2'd2
    } cause_e;

    typedef struct packed {
        cause_e              cause;
        logic [IW_DEF-1:0]   interval;
`ifdef ROLLOVER_MON_TS_EN
        logic [TS_W-1:0]     ts;
`endif
    } evt_rec_t;

    // Packed record width for an arbitrary interval field width.
    function automatic int rec_width(input int iw);
`ifdef ROLLOVER_MON_TS_EN
        return 2 + iw + TS_W;
`else
        return 2 + iw;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/rollover_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : rollover_monitor_if
// Brief    : Event drain port (valid/ready, record, level, drop count).
//            Carries ev_ts when ROLLOVER_MON_TS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface rollover_monitor_if
    import rollover_mon_pkg::*;
#(
    parameter int IW    = 8,
    parameter int DEPTH = 4,
    parameter int DW    = 8
);
    logic                     ev_valid;
    logic                     ev_ready;
    logic [1:0]               ev_cause;
    logic [IW-1:0]            ev_interval;
    logic [$clog2(DEPTH):0]   ev_level;
    logic [DW-1:0]            drop_cnt;
`ifdef ROLLOVER_MON_TS_EN
    logic [TS_W-1:0]          ev_ts;
`endif

    modport master (
`ifdef ROLLOVER_MON_TS_EN
        output ev_ts,
`endif
        output ev_valid,
        output ev_cause,
        output ev_interval,
        output ev_level,
        output drop_cnt,
        input  ev_ready
    );

    modport slave (
`ifdef ROLLOVER_MON_TS_EN
        input  ev_ts,
`endif
        input  ev_valid,
        input  ev_cause,
        input  ev_interval,
        input  ev_level,
        input  drop_cnt,
        output ev_ready
    );
endinterface
`default_nettype wire

// File: rtl/rollover_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rollover_evt_fifo
// Brief    : Generic synchronous first-word-fall-through FIFO with occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module rollover_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rstn,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_din,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_dout,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_level
);
    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   c_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == c_FULL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    // Head reads zero while empty so stale records never leak out.
    assign o_dout    = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/rollover_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rollover_monitor
// Brief    : Detects counter rollover events, classifies them, and queues
//            {cause, interval} records. ROLLOVER_MON_TS_EN adds a timestamp.
// Revision : 1.0 - initial release
// ============================================================================
module rollover_monitor
    import rollover_mon_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = 8,
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic [WIDTH-1:0] count,
    input  wire logic             rollover,
    input  wire logic             down,
    input  wire logic             load_en,
    rollover_monitor_if.master    ev
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int RW = rec_width(IW);

    typedef struct packed {
        cause_e            cause;
        logic [IW-1:0]     interval;
`ifdef ROLLOVER_MON_TS_EN
        logic [TS_W-1:0]   ts;
`endif
    } rec_t;

    logic            r_roll_q;
    logic            r_load_en_q;
    logic            r_down_q;
    logic [IW-1:0]   r_ival;
    logic [DW-1:0]   r_drop;
`ifdef ROLLOVER_MON_TS_EN
    logic [TS_W-1:0] r_ts;
`endif

    logic            w_evt;
    logic            w_pop;
    logic            w_push;
    logic            w_full;
    logic            w_empty;
    logic [LW-1:0]   w_level;
    logic [RW-1:0]   w_dout;
    rec_t            w_rec_in;
    rec_t            w_rec_out;
    logic            w_count_unused;

    // rollover already encodes the all-ones condition; count is only tapped.
    assign w_count_unused = ^count;

    assign w_evt  = rollover & ~r_roll_q;
    assign w_pop  = ~w_empty & ev.ev_ready;
    assign w_push = w_evt & (~w_full | w_pop);

    always_comb begin
        w_rec_in = '0;
        if (r_load_en_q) begin
            w_rec_in.cause = CAUSE_LOAD;
        end else if (r_down_q) begin
            w_rec_in.cause = CAUSE_DOWN_WRAP;
        end else begin
            w_rec_in.cause = CAUSE_UP;
        end
        w_rec_in.interval = (r_ival == '1) ? r_ival : r_ival + IW'(1);
`ifdef ROLLOVER_MON_TS_EN
        w_rec_in.ts = r_ts;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_roll_q    <= 1'b0;
            r_load_en_q <= 1'b0;
            r_down_q    <= 1'b0;
            r_ival      <= '0;
            r_drop      <= '0;
`ifdef ROLLOVER_MON_TS_EN
            r_ts        <= '0;
`endif
        end else begin
            r_roll_q    <= rollover;
            r_load_en_q <= load_en;
            r_down_q    <= down;
            // Interval restarts on every event, including dropped ones.
            if (w_evt) begin
                r_ival <= '0;
            end else if (r_ival != '1) begin
                r_ival <= r_ival + IW'(1);
            end
            if (w_evt && !w_push && (r_drop != '1)) begin
                r_drop <= r_drop + DW'(1);
            end
`ifdef ROLLOVER_MON_TS_EN
            r_ts <= r_ts + TS_W'(1);
`endif
        end
    end

    rollover_evt_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_din   (w_rec_in),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign w_rec_out      = rec_t'(w_dout);
    assign ev.ev_valid    = ~w_empty;
    assign ev.ev_cause    = w_rec_out.cause;
    assign ev.ev_interval = w_rec_out.interval;
    assign ev.ev_level    = w_level;
    assign ev.drop_cnt    = r_drop;
`ifdef ROLLOVER_MON_TS_EN
    assign ev.ev_ts       = w_rec_out.ts;
`endif
endmodule
`default_nettype wire
